// File: rtl/mouse_pos_latch.sv
// Mouse input conditioning: captures and clamps position, publishes it once per frame
// at the vblnk rising edge, debounces the left button and classifies click vs drag.
module mouse_pos_latch #(
  parameter int H_RES        = 800,
  parameter int V_RES        = 600,
  parameter int DEBOUNCE_CYC = 65536,
  parameter int HOLD_FRAMES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos_raw,
  input  logic [11:0] ypos_raw,
  input  logic        left_raw,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        frame_tick,
  output logic        left_held,
  output logic        left_click,
  output logic        drag_active
);

  // state   | meaning
  // S_IDLE  | button released, waiting for a debounced press
  // S_PRESS | button down, counting frame ticks toward drag
  // S_DRAG  | button held long enough; drag_active asserted
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_DRAG} state_t;

  localparam logic [11:0] X_MAX = 12'(H_RES - 1);
  localparam logic [11:0] Y_MAX = 12'(V_RES - 1);
  localparam int DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HF_W = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HF_W-1:0] HOLD_LAST = HF_W'(HOLD_FRAMES - 1);

  logic [11:0]     r_x_cap, r_y_cap, r_xpos, r_ypos;
  logic            r_vblnk_q, r_frame_tick;
  logic            r_sync1, r_left_sync, r_left_db;
  logic [DB_W-1:0] r_db_cnt;
  logic [HF_W-1:0] r_hold_cnt, w_hold_nxt;
  state_t          r_state, w_state_nxt;
  logic            r_click, r_drag, w_click_nxt, w_drag_nxt;
  logic [11:0]     w_x_clmp, w_y_clmp;
  logic            w_vblnk_rise;

  assign w_x_clmp     = (r_x_cap > X_MAX) ? X_MAX : r_x_cap;
  assign w_y_clmp     = (r_y_cap > Y_MAX) ? Y_MAX : r_y_cap;
  assign w_vblnk_rise = vblnk & ~r_vblnk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_cap      <= '0;
      r_y_cap      <= '0;
      r_xpos       <= '0;
      r_ypos       <= '0;
      r_vblnk_q    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_sync1      <= 1'b0;
      r_left_sync  <= 1'b0;
      r_left_db    <= 1'b0;
      r_db_cnt     <= '0;
    end else begin
      r_x_cap      <= xpos_raw;
      r_y_cap      <= ypos_raw;
      r_vblnk_q    <= vblnk;
      r_frame_tick <= w_vblnk_rise;
      // Publishing only at blanking start keeps the cursor from tearing mid-frame
      if (w_vblnk_rise) begin
        r_xpos <= w_x_clmp;
        r_ypos <= w_y_clmp;
      end
      r_sync1     <= left_raw;
      r_left_sync <= r_sync1;
      if (r_left_sync == r_left_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_left_db <= r_left_sync;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_click    <= 1'b0;
      r_drag     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_click    <= w_click_nxt;
      r_drag     <= w_drag_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_click_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_left_db) begin
          w_state_nxt = S_PRESS;
          w_hold_nxt  = '0;
        end
      end
      S_PRESS: begin
        // A release seen together with a frame tick is still a click
        if (!r_left_db) begin
          w_state_nxt = S_IDLE;
          w_click_nxt = 1'b1;
        end else if (r_frame_tick) begin
          if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_DRAG;
          else                         w_hold_nxt  = r_hold_cnt + HF_W'(1);
        end
      end
      S_DRAG: begin
        if (!r_left_db) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_drag_nxt = (w_state_nxt == S_DRAG);
  end

  assign xpos        = r_xpos;
  assign ypos        = r_ypos;
  assign frame_tick  = r_frame_tick;
  assign left_held   = r_left_db;
  assign left_click  = r_click;
  assign drag_active = r_drag;

endmodule

// File: tb/tb_mouse_pos_latch.sv
// Directed bench for mouse_pos_latch with DEBOUNCE_CYC=4, HOLD_FRAMES=4.
module tb_mouse_pos_latch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] xpos_raw, ypos_raw;
  logic        left_raw, vblnk;
  logic [11:0] xpos, ypos;
  logic        frame_tick, left_held, left_click, drag_active;
  int n_vec = 0;
  int n_err = 0;

  mouse_pos_latch #(.H_RES(800), .V_RES(600), .DEBOUNCE_CYC(4), .HOLD_FRAMES(4)) dut (
    .clk(clk), .rst_n(rst_n), .xpos_raw(xpos_raw), .ypos_raw(ypos_raw),
    .left_raw(left_raw), .vblnk(vblnk), .xpos(xpos), .ypos(ypos),
    .frame_tick(frame_tick), .left_held(left_held), .left_click(left_click),
    .drag_active(drag_active)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Leaves frame_tick visible in the current cycle; vblnk stays high.
  task automatic frame();
    vblnk = 1'b0;
    tick(1);
    vblnk = 1'b1;
    tick(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {xpos[11:0] | ypos[11:0]} | 12'({frame_tick, left_held, left_click, drag_active}), 12'd0);
  endtask

  initial begin
    rst_n = 1'b0; xpos_raw = 12'd100; ypos_raw = 12'd0; left_raw = 1'b0; vblnk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vblnk = ~vblnk;
      tick(1);
      chk_all_zero("reset_outputs");
    end

    rst_n = 1'b1; vblnk = 1'b0; xpos_raw = 12'd100; ypos_raw = 12'd50;
    tick(2);
    chk("xpos_before_tick", xpos, 12'd0);
    vblnk = 1'b1;
    tick(1);
    chk("tick_pulse", 12'(frame_tick), 12'd1);
    chk("xpos_load", xpos, 12'd100);
    chk("ypos_load", ypos, 12'd50);
    xpos_raw = 12'd200;
    tick(1);
    chk("tick_single", 12'(frame_tick), 12'd0);
    chk("xpos_hold", xpos, 12'd100);
    tick(3);
    chk("xpos_hold_vblnk_high", xpos, 12'd100);
    frame();
    chk("xpos_next_frame", xpos, 12'd200);

    xpos_raw = 12'd1023; ypos_raw = 12'd4095;
    frame();
    chk("clamp_x", xpos, 12'd799);
    chk("clamp_y", ypos, 12'd599);
    xpos_raw = 12'd799; ypos_raw = 12'd598;
    frame();
    chk("x_at_max", xpos, 12'd799);
    chk("y_below_max", ypos, 12'd598);
    xpos_raw = 12'd800; ypos_raw = 12'd600;
    frame();
    chk("clamp_x_800", xpos, 12'd799);
    chk("clamp_y_600", ypos, 12'd599);

    vblnk = 1'b0;
    tick(2);
    left_raw = 1'b1;
    tick(3);
    left_raw = 1'b0;
    tick(10);
    chk("glitch_ignored", 12'(left_held), 12'd0);
    chk("glitch_no_click", 12'(left_click), 12'd0);

    // Short click: two frames in PRESS, then release
    left_raw = 1'b1;
    tick(5);
    chk("db_latency_5", 12'(left_held), 12'd0);
    tick(1);
    chk("db_latency_6", 12'(left_held), 12'd1);
    tick(1);
    frame();
    frame();
    left_raw = 1'b0;
    tick(6);
    chk("short_release_held", 12'(left_held), 12'd0);
    chk("short_no_click_yet", 12'(left_click), 12'd0);
    tick(1);
    chk("short_click", 12'(left_click), 12'd1);
    chk("short_no_drag", 12'(drag_active), 12'd0);
    tick(1);
    chk("short_click_single", 12'(left_click), 12'd0);

    // Release lands on the same cycle as the 4th frame tick
    left_raw = 1'b1;
    tick(7);
    frame();
    frame();
    frame();
    left_raw = 1'b0;
    tick(4);
    vblnk = 1'b0;
    tick(1);
    vblnk = 1'b1;
    tick(1);
    chk("race_held_low", 12'(left_held), 12'd0);
    chk("race_tick", 12'(frame_tick), 12'd1);
    tick(1);
    chk("race_click", 12'(left_click), 12'd1);
    chk("race_no_drag", 12'(drag_active), 12'd0);
    tick(2);
    chk("race_still_no_drag", 12'(drag_active), 12'd0);

    // Drag and release
    left_raw = 1'b1;
    tick(7);
    frame();
    frame();
    frame();
    frame();
    chk("drag_not_yet", 12'(drag_active), 12'd0);
    tick(1);
    chk("drag_start", 12'(drag_active), 12'd1);
    chk("drag_no_click", 12'(left_click), 12'd0);
    left_raw = 1'b0;
    tick(6);
    chk("drag_held_low", 12'(left_held), 12'd0);
    chk("drag_still_active", 12'(drag_active), 12'd1);
    tick(1);
    chk("drag_end", 12'(drag_active), 12'd0);
    chk("drag_end_no_click", 12'(left_click), 12'd0);
    tick(1);
    chk("drag_end_no_click2", 12'(left_click), 12'd0);

    // Reset during drag
    left_raw = 1'b1;
    tick(7);
    frame();
    frame();
    frame();
    frame();
    tick(1);
    chk("drag_before_reset", 12'(drag_active), 12'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst_drag_off", 12'(drag_active), 12'd0);
    chk_all_zero("rst_all_zero");
    tick(5);
    chk("rst_held_5", 12'(left_held), 12'd0);
    chk("rst_no_drag", 12'(drag_active), 12'd0);
    tick(1);
    chk("rst_held_6", 12'(left_held), 12'd1);
    tick(1);
    chk("rst_idle_no_drag", 12'(drag_active), 12'd0);
    chk("rst_idle_no_click", 12'(left_click), 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mouse_pos_latch.md
Name: mouse_pos_latch

Overview:
- Conditions the raw mouse controller outputs (position, left button) before they reach the mouse-overlay drawing stage.
- Registers the position and clamps it to the visible area.
- Updates the published position only once per frame, at the start of vertical blanking, so the cursor never tears mid-frame.
- Debounces the left button and runs a click/drag state machine; results feed the downstream drawing and game-logic stages.

Parameters:
- H_RES, 800, horizontal visible pixels; xpos is clamped to H_RES-1.
- V_RES, 600, vertical visible lines; ypos is clamped to V_RES-1.
- DEBOUNCE_CYC, 65536, consecutive stable clocks required before the debounced button changes level (minimum 2).
- HOLD_FRAMES, 4, number of frame ticks the button must stay held before drag starts (minimum 1).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- xpos_raw  in  12  mouse controller X position, unsigned.
- ypos_raw  in  12  mouse controller Y position, unsigned.
- left_raw  in  1  mouse controller left button, asynchronous to pixel timing.
- vblnk  in  1  vertical blanking from the VGA timing chain.
- xpos  out  12  frame-stable, clamped X position.
- ypos  out  12  frame-stable, clamped Y position.
- frame_tick  out  1  one-cycle pulse at each vblnk rising edge.
- left_held  out  1  debounced left button level.
- left_click  out  1  one-cycle pulse on a short press-release (release before drag starts).
- drag_active  out  1  high while in the DRAG state.

Behaviour:
- Reset:
  - rst_n=0 sampled at posedge clk forces all outputs to 0.
  - Synchroniser, capture registers, counters and vblnk history are cleared; FSM goes to IDLE.
  - Reset is synchronous and overrides every other event in the same cycle, including mid-drag: drag_active is 0 on the cycle after the reset edge.
- Capture:
  - xpos_raw and ypos_raw are registered every clock into x_cap and y_cap.
- Clamp:
  - x_clmp = (x_cap > H_RES-1) ? H_RES-1 : x_cap; y_clmp is computed the same way against V_RES-1.
  - Unsigned 12-bit compare; no wrap.
- Frame tick:
  - vblnk_q holds vblnk delayed by one clock.
  - When vblnk=1 and vblnk_q=0 at an edge, frame_tick=1 for exactly the next cycle.
  - vblnk held high produces no further ticks.
- Position update:
  - On the edge that raises frame_tick, xpos and ypos load x_clmp and y_clmp.
  - Otherwise they hold. Raw changes never reach the outputs between ticks.
- Button synchroniser:
  - left_raw passes through a 2-flop synchroniser to give left_sync.
- Debounce:
  - db_cnt is cleared whenever left_sync == left_db; otherwise it increments.
  - When db_cnt == DEBOUNCE_CYC-1 and left_sync still differs, left_db takes left_sync and db_cnt is cleared.
  - Net latency from left_raw to left_held is 2 + DEBOUNCE_CYC clocks.
  - Glitches shorter than DEBOUNCE_CYC clocks are ignored.
  - left_held = left_db.
- FSM states: IDLE, PRESS, DRAG.
  - IDLE: if left_db=1, go to PRESS and clear hold_cnt.
  - PRESS, left_db=0: go to IDLE and pulse left_click for 1 cycle.
  - PRESS, left_db=1 with frame_tick: if hold_cnt == HOLD_FRAMES-1, go to DRAG; else increment hold_cnt.
  - DRAG: drag_active=1. When left_db=0, go to IDLE with no left_click.
  - Release and frame_tick in the same cycle while in PRESS: release wins (IDLE plus left_click, no drag).
- Output timing:
  - left_click and drag_active are registered and change on the edge following the FSM transition decision.
  - left_click is never asserted together with drag_active.

Test Plan:
- Reset and frame gating:
  - Hold rst_n=0 for 5 clocks with xpos_raw=100 and vblnk toggling → all outputs 0 throughout.
  - Release reset, set xpos_raw=100, ypos_raw=50, then raise vblnk → frame_tick is a single pulse and xpos=100, ypos=50 from that cycle on.
  - Change xpos_raw to 200 with vblnk held high → xpos stays 100 until the next vblnk rise.
- Clamping:
  - xpos_raw=1023, ypos_raw=4095, then a vblnk rise → xpos=799, ypos=599.
  - xpos_raw=799 → xpos=799 exactly (no off-by-one).
- Debounce (DEBOUNCE_CYC=4):
  - A 3-clock left_raw glitch → left_held stays 0.
  - left_raw held high → left_held rises exactly 6 clocks after left_raw rises.
- Short click (HOLD_FRAMES=4, DEBOUNCE_CYC=4):
  - Press, hold across 2 frame ticks, release → exactly one left_click pulse; drag_active never 1.
  - Release coinciding with the 4th frame tick → left_click pulse, no drag.
- Drag:
  - Press and hold across 4 frame ticks → drag_active=1 on the cycle after the 4th tick.
  - Release → drag_active=0 after debounce latency, no left_click.
  - With drag_active=1, pulse rst_n low for 1 clock → drag_active=0 next cycle and FSM in IDLE; left_held=0 until 6 clocks of stable high.
